// File: rtl/sort_pkg.sv
// Shared types and defaults for the streaming insertion sorter.
package sort_pkg;

    localparam int SORT_N = 5;
    localparam int SORT_W = 6;

    typedef enum logic [0:0] {
        LOAD = 1'b0,
        EMIT = 1'b1
    } sort_state_t;

    // Reference insertion position: number of stored entries <= key (stable for equal keys).
    function automatic int unsigned sort_pos(
        input logic [SORT_N-1:0][SORT_W-1:0] entries,
        input int unsigned                   count,
        input logic [SORT_W-1:0]             key
    );
        int unsigned pos;
        pos = 0;
        for (int unsigned i = 0; i < SORT_N; i++) begin
            if (i < count && entries[i] <= key) pos++;
        end
        return pos;
    endfunction

endpackage

// File: rtl/sort_insert_slice.sv
// One sorted-buffer cell: holds, shifts in its left neighbour, or takes the new sample.
module sort_insert_slice
    import sort_pkg::*;
#(
    parameter int W   = SORT_W,
    parameter int CW  = 3,
    parameter int IDX = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          accept,
    input  logic [W-1:0]  key,
    input  logic [CW-1:0] count,
    input  logic [W-1:0]  left,
    input  logic          left_moves,
    output logic          moves,
    output logic [W-1:0]  value,
    output logic [W-1:0]  next
);

    // An entry is displaced when it is strictly greater than the key, or it is the first free slot.
    // Strict compare keeps equal samples in arrival order.
    always_comb begin
        moves = ((CW'(IDX) < count) && (value > key)) || (CW'(IDX) == count);
        next  = value;
        if (accept && moves) begin
            next = left_moves ? left : key;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else begin
            value <= next;
        end
    end

endmodule

// File: rtl/sort_stream.sv
// Streaming frame sorter: insertion-sorts N serial samples, then emits them ascending with the median.
module sort_stream
    import sort_pkg::*;
#(
    parameter int N = SORT_N,
    parameter int W = SORT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_num,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_num,
    output logic         out_last,
    output logic [W-1:0] median,
    output logic         median_valid
);

    localparam int CW  = $clog2(N + 1);
    localparam int MID = N / 2;

    sort_state_t   state;
    logic [CW-1:0] count;
    logic [CW-1:0] rd_idx;
    logic [W-1:0]  entries [N];
    logic [W-1:0]  next    [N];
    logic          moves   [N];
    logic          accept;
    logic          xfer;

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == EMIT);
    assign out_last  = out_valid && (rd_idx == CW'(N - 1));
    assign out_num   = out_valid ? entries[rd_idx] : '0;
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    for (genvar i = 0; i < N; i++) begin : g_slice
        logic [W-1:0] left;
        logic         left_moves;
        if (i == 0) begin : g_head
            assign left       = '0;
            assign left_moves = 1'b0;
        end else begin : g_body
            assign left       = entries[i-1];
            assign left_moves = moves[i-1];
        end
        sort_insert_slice #(
            .W   (W),
            .CW  (CW),
            .IDX (i)
        ) u_slice (
            .clk        (clk),
            .rst_n      (rst_n),
            .accept     (accept),
            .key        (in_num),
            .count      (count),
            .left       (left),
            .left_moves (left_moves),
            .moves      (moves[i]),
            .value      (entries[i]),
            .next       (next[i])
        );
    end

    // Median is taken from the post-insertion values so it includes the final sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= LOAD;
            count        <= '0;
            rd_idx       <= '0;
            median       <= '0;
            median_valid <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        count <= count + 1'b1;
                        if (count == CW'(N - 1)) begin
                            state        <= EMIT;
                            median       <= next[MID];
                            median_valid <= 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (xfer) begin
                        if (rd_idx == CW'(N - 1)) begin
                            state        <= LOAD;
                            count        <= '0;
                            rd_idx       <= '0;
                            median_valid <= 1'b0;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: doc/sort_stream.md
Name: sort_stream

Overview:
- Sequential counterpart to the team's combinational 5-input sorter.
- Sorts a serially delivered frame of N samples. It accepts one sample per cycle through a valid/ready handshake and sorts each sample on arrival by insertion.
- Once the frame is complete, it emits the frame in ascending order through a valid/ready handshake, and presents the median.
- Sits between a serial data source and consumers that need ranked data. It replaces the need to collect all operands in parallel.

Parameters:
- N, 5, samples per frame (≥2).
- W, 6, sample width in bits.
- CW, $clog2(N+1), counter width (derived, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_num carries a sample.
- in_num  input  W  unsigned sample.
- in_ready  output  1  block can accept a sample.
- out_valid  output  1  out_num carries a sorted sample.
- out_ready  input  1  downstream accepts out_num.
- out_num  output  W  current sorted sample, smallest first.
- out_last  output  1  out_num is the largest (final) sample of the frame.
- median  output  W  element N/2 (integer division) of the sorted frame.
- median_valid  output  1  median holds the current frame's value.

Behaviour:
- Reset (asynchronous assert, synchronous deassert by the upstream reset tree):
  - State = LOAD, count = 0, rd_idx = 0.
  - Sorted buffer entries = 0.
  - in_ready = 1; out_valid, out_last, median_valid = 0; out_num = 0; median = 0.
- Reset mid-frame or mid-emit discards the frame. No partial output follows reset.
- All outputs are registered or derived only from state registers. No combinational path from in_* to out_*. in_ready depends only on state.
- State LOAD (in_ready=1, out_valid=0):
  - Accept occurs when in_valid & in_ready.
  - On accept, in_num is inserted into buf[0..count]. Entries ≥ position shift up one. Position = number of stored entries ≤ in_num.
  - Equal values are stable: the new sample goes after existing equal samples.
  - count increments on each accept.
  - The accept that makes count reach N moves the state to EMIT at the next edge. The same edge latches median = sorted buf[N/2] including the new sample, and sets median_valid = 1.
  - in_valid low: no change. Bubbles are allowed anywhere in the frame.
- State EMIT (in_ready=0, out_valid=1):
  - out_num = buf[rd_idx]; out_last = (rd_idx == N-1).
  - Transfer occurs when out_valid & out_ready; rd_idx then increments.
  - out_ready low holds out_num and out_last stable.
  - Transfer with out_last: the next edge returns to LOAD with count=0, rd_idx=0, out_valid=0, median_valid=0. in_ready=1 in that same next cycle.
  - in_valid asserted during EMIT is ignored; the sample is not consumed.
- Latency:
  - The Nth accept at edge t gives out_valid=1 with the smallest sample in the cycle after t.
  - Back-to-back frame throughput = 2N cycles with no stalls.
- Arithmetic: unsigned W-bit compares only; no wrap-around concerns. count and rd_idx never exceed N (count) / N-1 (rd_idx).
- Buffer entries at index ≥ count hold stale data in LOAD. They are never visible on out_num.

Decomposition:
- Package sort_pkg holds:
  - the state enum typedef (LOAD, EMIT);
  - localparam defaults SORT_N=5 and SORT_W=6;
  - a function for insertion position (count of entries ≤ key).
- One natural sub-module, sort_insert_slice. It is a per-entry cell holding one buf register that chooses among hold, take the left neighbour (shift), or take the new sample, based on its compare result and its neighbour's compare result. sort_stream instantiates N slices with generate.

Test Plan:
- Reset mid-LOAD: inputs 9,3 then assert rst_n=0 → in_ready=1, out_valid=0, median_valid=0. A fresh frame 1,2,3,4,5 emits exactly 1,2,3,4,5.
- Frame 42,7,63,0,19 with out_ready=1 →
  - out_num sequence 0,7,19,42,63, one per cycle, starting the cycle after the 5th accept;
  - out_last only with 63;
  - median=19, median_valid=1 during EMIT.
- Duplicates 5,5,2,5,2 → out_num 2,2,5,5,5; median=5.
- Backpressure: frame 10,20,30,40,50 with out_ready toggling 1,0,0,1,... → each value is held while out_ready=0. No value is skipped or repeated; 50 carries out_last.
- Input bubbles and ignored input: in_valid pattern 1,0,1,1,0,1,1 delivering 4,3,2,1,0 → output 0,1,2,3,4. in_valid=1 with value 33 during EMIT → 33 does not appear, in_ready=0.
- Back-to-back frames: frame A 63,62,61,60,59 then frame B 1,1,1,1,0, presented as soon as in_ready returns → A emits 59..63. in_ready=1 in the cycle after A's last transfer. B emits 0,1,1,1,1; median=1.
